// File: rtl/alu_pkg.sv
// Shared opcode encoding, FSM state type and flag bit positions for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_NOR   = 4'd4;
    localparam logic [3:0] OP_MUL   = 4'd5;
    localparam logic [3:0] OP_SLL   = 4'd6;
    localparam logic [3:0] OP_SLTU  = 4'd7;
    localparam logic [3:0] OP_MAX   = 4'd8;
    localparam logic [3:0] OP_PASSB = 4'd9;
    localparam logic [3:0] OP_SLT   = 4'd10;
    localparam logic [3:0] OP_MAXS  = 4'd11;
    localparam logic [3:0] OP_SRA   = 4'd12;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } state_e;

    localparam int FLAG_CARRY = 0;
    localparam int FLAG_ZERO  = 1;
    localparam int FLAG_SIGN  = 2;
    localparam int NUM_FLAGS  = 3;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: retires MUL_BITS multiplier bits per cycle, the first
// chunk on the start cycle itself, and pulses done once the full 2*WIDTH product is ready.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int MUL_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     op_a,
    input  logic [WIDTH-1:0]     op_b,
    output logic [2*WIDTH-1:0]   product,
    output logic                 done
);

    localparam int STEPS = WIDTH / MUL_BITS;
    localparam int CW    = $clog2(STEPS + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(STEPS - 1);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      count_q, count_d;
    logic               done_q, done_d;

    logic [2*WIDTH-1:0] src_acc;
    logic [2*WIDTH-1:0] src_mcand;
    logic [WIDTH-1:0]   src_mplier;
    logic [2*WIDTH-1:0] partial;
    logic               stepping;

    // On start the operands bypass the registers so the first chunk is retired immediately.
    always_comb begin
        src_acc    = acc_q;
        src_mcand  = mcand_q;
        src_mplier = mplier_q;
        if (start) begin
            src_acc    = '0;
            src_mcand  = {{WIDTH{1'b0}}, op_a};
            src_mplier = op_b;
        end

        stepping = start || (count_q != '0);

        partial = '0;
        for (int i = 0; i < MUL_BITS; i++) begin
            if (src_mplier[i]) begin
                partial = partial + (src_mcand << i);
            end
        end

        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        done_d   = 1'b0;
        if (stepping) begin
            acc_d    = src_acc + partial;
            mcand_d  = src_mcand << MUL_BITS;
            mplier_d = src_mplier >> MUL_BITS;
            count_d  = start ? LAST_COUNT : (count_q - CW'(1));
            done_d   = (count_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
            done_q   <= done_d;
        end
    end

    assign product = acc_q;
    assign done    = done_q;

endmodule

// File: rtl/alu_seq_pipe.sv
// Handshaked ALU with registered result/flags and an iterative multiplier.
// Define ALU_SIGNED_OPS_EN to add the signed opcodes SLT, MAXS and SRA.
module alu_seq_pipe
    import alu_pkg::*;
#(
    parameter  int WIDTH    = 64,
    parameter  int MUL_BITS = 1,
    localparam int SHW      = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic [SHW-1:0]   shiftValue,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carryFlag,
    output logic             zeroFlag,
    output logic             signFlag
);

    state_e                 state_q, state_d;
    logic                   out_valid_q, out_valid_d;
    logic [WIDTH-1:0]       result_q, result_d;
    logic [NUM_FLAGS-1:0]   flags_q, flags_d;

    logic                   accept;
    logic                   is_mul;
    logic                   mul_start;
    logic                   mul_done;
    logic [2*WIDTH-1:0]     mul_product;

    logic [WIDTH-1:0]       alu_result;
    logic                   alu_carry;
    logic [WIDTH:0]         sum;
    logic [WIDTH:0]         sll_ext;
`ifdef ALU_SIGNED_OPS_EN
    logic signed [WIDTH:0]  sra_ext;
    logic                   lt_signed;
`endif

    logic                   wb_en;
    logic [WIDTH-1:0]       wb_result;
    logic                   wb_carry;

    assign in_ready  = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign is_mul    = (opcode == OP_MUL);
    assign mul_start = accept && is_mul;

    alu_mul_iter #(
        .WIDTH    (WIDTH),
        .MUL_BITS (MUL_BITS)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .op_a    (input1),
        .op_b    (input2),
        .product (mul_product),
        .done    (mul_done)
    );

    // The extra guard bit on each shift captures the last bit shifted out as the carry.
    always_comb begin
        sum     = {1'b0, input1} + {1'b0, input2};
        sll_ext = {1'b0, input1} << shiftValue;
`ifdef ALU_SIGNED_OPS_EN
        sra_ext   = $signed({input1, 1'b0}) >>> shiftValue;
        lt_signed = $signed(input1) < $signed(input2);
`endif
        alu_result = '0;
        alu_carry  = 1'b0;
        case (opcode)
            OP_ADD: begin
                alu_result = sum[WIDTH-1:0];
                alu_carry  = sum[WIDTH];
            end
            OP_SUB: begin
                alu_result = input1 - input2;
                alu_carry  = (input1 < input2);
            end
            OP_AND:   alu_result = input1 & input2;
            OP_OR:    alu_result = input1 | input2;
            OP_NOR:   alu_result = ~(input1 | input2);
            OP_SLL: begin
                alu_result = sll_ext[WIDTH-1:0];
                alu_carry  = sll_ext[WIDTH];
            end
            OP_SLTU:  alu_result = {{(WIDTH-1){1'b0}}, (input1 < input2)};
            OP_MAX:   alu_result = (input1 > input2) ? input1 : input2;
            OP_PASSB: alu_result = input2;
`ifdef ALU_SIGNED_OPS_EN
            OP_SLT:   alu_result = {{(WIDTH-1){1'b0}}, lt_signed};
            OP_MAXS:  alu_result = lt_signed ? input2 : input1;
            OP_SRA: begin
                alu_result = sra_ext[WIDTH:1];
                alu_carry  = sra_ext[0];
            end
`endif
            default: begin
                alu_result = '0;
                alu_carry  = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q && !out_ready;
        result_d    = result_q;
        flags_d     = flags_q;

        wb_en     = 1'b0;
        wb_result = alu_result;
        wb_carry  = alu_carry;

        if (accept && !is_mul) begin
            wb_en = 1'b1;
        end
        if (mul_start) begin
            state_d = MUL_BUSY;
        end
        if ((state_q == MUL_BUSY) && mul_done) begin
            state_d   = IDLE;
            wb_en     = 1'b1;
            wb_result = mul_product[WIDTH-1:0];
            wb_carry  = |mul_product[2*WIDTH-1:WIDTH];
        end

        if (wb_en) begin
            out_valid_d         = 1'b1;
            result_d            = wb_result;
            flags_d[FLAG_CARRY] = wb_carry;
            flags_d[FLAG_ZERO]  = (wb_result == '0);
            flags_d[FLAG_SIGN]  = wb_result[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign carryFlag = flags_q[FLAG_CARRY];
    assign zeroFlag  = flags_q[FLAG_ZERO];
    assign signFlag  = flags_q[FLAG_SIGN];

endmodule

// File: tb/tb_alu_seq_pipe.sv
// Directed testbench for alu_seq_pipe: WIDTH=64 with MUL_BITS=1 and a MUL_BITS=4 instance.
module tb_alu_seq_pipe;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;

    logic        in_valid;
    logic        in_ready;
    logic [3:0]  opcode;
    logic [63:0] input1;
    logic [63:0] input2;
    logic [5:0]  shift_value;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        carry_flag;
    logic        zero_flag;
    logic        sign_flag;

    logic        m4_in_valid;
    logic        m4_in_ready;
    logic [3:0]  m4_opcode;
    logic [63:0] m4_input1;
    logic [63:0] m4_input2;
    logic [5:0]  m4_shift_value;
    logic        m4_out_valid;
    logic        m4_out_ready;
    logic [63:0] m4_result;
    logic        m4_carry_flag;
    logic        m4_zero_flag;
    logic        m4_sign_flag;

    int compared   = 0;
    int mismatched = 0;

    alu_seq_pipe #(.WIDTH(64), .MUL_BITS(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opcode     (opcode),
        .input1     (input1),
        .input2     (input2),
        .shiftValue (shift_value),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .carryFlag  (carry_flag),
        .zeroFlag   (zero_flag),
        .signFlag   (sign_flag)
    );

    alu_seq_pipe #(.WIDTH(64), .MUL_BITS(4)) dut_m4 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (m4_in_valid),
        .in_ready   (m4_in_ready),
        .opcode     (m4_opcode),
        .input1     (m4_input1),
        .input2     (m4_input2),
        .shiftValue (m4_shift_value),
        .out_valid  (m4_out_valid),
        .out_ready  (m4_out_ready),
        .result     (m4_result),
        .carryFlag  (m4_carry_flag),
        .zeroFlag   (m4_zero_flag),
        .signFlag   (m4_sign_flag)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkAlu(input string tag, input logic [63:0] exp_result,
                            input logic exp_carry, input logic exp_zero, input logic exp_sign);
        checkOutput({tag, ".out_valid"}, 64'(out_valid), 64'd1);
        checkOutput({tag, ".result"},    result,         exp_result);
        checkOutput({tag, ".carry"},     64'(carry_flag), 64'(exp_carry));
        checkOutput({tag, ".zero"},      64'(zero_flag),  64'(exp_zero));
        checkOutput({tag, ".sign"},      64'(sign_flag),  64'(exp_sign));
    endtask

    // Presents one op at the falling edge, confirms it is accepted, returns 1ns after the accepting edge.
    task automatic applyStimulus(input string tag, input logic [3:0] op,
                                 input logic [63:0] a, input logic [63:0] b, input logic [5:0] sh);
        @(negedge clk);
        in_valid    = 1'b1;
        opcode      = op;
        input1      = a;
        input2      = b;
        shift_value = sh;
        #1;
        checkOutput({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  lat;
        bit  saw_ready;
        bit  saw_valid;

        rst            = 1'b1;
        in_valid       = 1'b0;
        opcode         = OP_ADD;
        input1         = '0;
        input2         = '0;
        shift_value    = '0;
        out_ready      = 1'b1;
        m4_in_valid    = 1'b0;
        m4_opcode      = OP_ADD;
        m4_input1      = '0;
        m4_input2      = '0;
        m4_shift_value = '0;
        m4_out_ready   = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        $display("[TB] reset state");
        checkOutput("reset.out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset.result",    result,         64'd0);
        checkOutput("reset.carry",     64'(carry_flag), 64'd0);
        checkOutput("reset.zero",      64'(zero_flag),  64'd0);
        checkOutput("reset.sign",      64'(sign_flag),  64'd0);
        checkOutput("reset.in_ready",  64'(in_ready),   64'd1);
        rst = 1'b0;

        $display("[TB] single-cycle operations");
        applyStimulus("add_wrap", OP_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 6'd0);
        checkAlu("add_wrap", 64'd0, 1'b1, 1'b1, 1'b0);
        applyStimulus("add_small", OP_ADD, 64'd2, 64'd3, 6'd0);
        checkAlu("add_small", 64'd5, 1'b0, 1'b0, 1'b0);
        applyStimulus("sub_borrow", OP_SUB, 64'd3, 64'd5, 6'd0);
        checkAlu("sub_borrow", 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b1);
        applyStimulus("sltu", OP_SLTU, 64'd3, 64'd5, 6'd0);
        checkAlu("sltu", 64'd1, 1'b0, 1'b0, 1'b0);
        applyStimulus("sltu_false", OP_SLTU, 64'd5, 64'd3, 6'd0);
        checkAlu("sltu_false", 64'd0, 1'b0, 1'b1, 1'b0);
        applyStimulus("and", OP_AND, 64'hF0F0, 64'hFF00, 6'd0);
        checkAlu("and", 64'hF000, 1'b0, 1'b0, 1'b0);
        applyStimulus("nor", OP_NOR, 64'd0, 64'd0, 6'd0);
        checkAlu("nor", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1);
        applyStimulus("max", OP_MAX, 64'd7, 64'h8000_0000_0000_0009, 6'd0);
        checkAlu("max", 64'h8000_0000_0000_0009, 1'b0, 1'b0, 1'b1);
        applyStimulus("passb", OP_PASSB, 64'd11, 64'h1234_5678_9ABC_DEF0, 6'd0);
        checkAlu("passb", 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0, 1'b0);
        applyStimulus("sll_carry", OP_SLL, 64'h8000_0000_0000_0001, 64'd0, 6'd1);
        checkAlu("sll_carry", 64'd2, 1'b1, 1'b0, 1'b0);
        applyStimulus("sll_zero_amt", OP_SLL, 64'h8000_0000_0000_0001, 64'd0, 6'd0);
        checkAlu("sll_zero_amt", 64'h8000_0000_0000_0001, 1'b0, 1'b0, 1'b1);
        applyStimulus("sll_63", OP_SLL, 64'd3, 64'd0, 6'd63);
        checkAlu("sll_63", 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1);
        applyStimulus("undef_op", 4'd15, 64'd9, 64'd9, 6'd0);
        checkAlu("undef_op", 64'd0, 1'b0, 1'b1, 1'b0);

`ifdef ALU_SIGNED_OPS_EN
        $display("[TB] signed operations");
        applyStimulus("slt", OP_SLT, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 6'd0);
        checkAlu("slt", 64'd1, 1'b0, 1'b0, 1'b0);
        applyStimulus("maxs", OP_MAXS, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 6'd0);
        checkAlu("maxs", 64'd1, 1'b0, 1'b0, 1'b0);
        applyStimulus("sra", OP_SRA, 64'h8000_0000_0000_0000, 64'd0, 6'd63);
        checkAlu("sra", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1);
        applyStimulus("sra_carry", OP_SRA, 64'h0000_0000_0000_0006, 64'd0, 6'd2);
        checkAlu("sra_carry", 64'd1, 1'b1, 1'b0, 1'b0);
`else
        $display("[TB] signed opcodes disabled");
        applyStimulus("op10_disabled", OP_SLT, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 6'd0);
        checkAlu("op10_disabled", 64'd0, 1'b0, 1'b1, 1'b0);
        applyStimulus("op12_disabled", OP_SRA, 64'h8000_0000_0000_0000, 64'd0, 6'd63);
        checkAlu("op12_disabled", 64'd0, 1'b0, 1'b1, 1'b0);
`endif

        $display("[TB] iterative multiply, MUL_BITS=1");
        applyStimulus("mul_hi", OP_MUL, 64'h1_0000_0000, 64'h1_0000_0000, 6'd0);
        lat       = 1;
        saw_ready = 1'b0;
        while (!out_valid && lat < 200) begin
            if (in_ready) saw_ready = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("mul_hi.latency", 64'(lat), 64'd65);
        checkOutput("mul_hi.in_ready_busy", 64'(saw_ready), 64'd0);
        checkAlu("mul_hi", 64'd0, 1'b1, 1'b1, 1'b0);

        applyStimulus("mul_x2", OP_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 6'd0);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("mul_x2.latency", 64'(lat), 64'd65);
        checkAlu("mul_x2", 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b1);

        applyStimulus("mul_small", OP_MUL, 64'h1234, 64'h10, 6'd0);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkAlu("mul_small", 64'h12340, 1'b0, 1'b0, 1'b0);

        $display("[TB] iterative multiply, MUL_BITS=4");
        @(negedge clk);
        m4_in_valid = 1'b1;
        m4_opcode   = OP_MUL;
        m4_input1   = 64'hFFFF_FFFF_FFFF_FFFF;
        m4_input2   = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        checkOutput("mul4.in_ready", 64'(m4_in_ready), 64'd1);
        @(posedge clk);
        #1;
        m4_in_valid = 1'b0;
        lat = 1;
        while (!m4_out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("mul4.latency", 64'(lat), 64'd17);
        checkOutput("mul4.result",  m4_result, 64'd1);
        checkOutput("mul4.carry",   64'(m4_carry_flag), 64'd1);
        checkOutput("mul4.zero",    64'(m4_zero_flag),  64'd0);

        $display("[TB] output stall and same-cycle pop/accept");
        @(negedge clk);
        out_ready = 1'b0;
        applyStimulus("stall_add", OP_ADD, 64'd2, 64'd2, 6'd0);
        checkAlu("stall_add", 64'd4, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("stall.out_valid", 64'(out_valid), 64'd1);
        checkOutput("stall.result",    result,         64'd4);
        checkOutput("stall.in_ready",  64'(in_ready),  64'd0);
        in_valid  = 1'b1;
        opcode    = OP_OR;
        input1    = 64'hF0;
        input2    = 64'h0F;
        out_ready = 1'b1;
        #1;
        checkOutput("popaccept.in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkAlu("popaccept_or", 64'hFF, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("drain.out_valid", 64'(out_valid), 64'd0);

        $display("[TB] reset during multiply");
        applyStimulus("mul_abort", OP_MUL, 64'd5, 64'd7, 6'd0);
        repeat (29) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort.out_valid", 64'(out_valid), 64'd0);
        checkOutput("abort.result",    result,         64'd0);
        checkOutput("abort.in_ready",  64'(in_ready),  64'd1);
        rst       = 1'b0;
        saw_valid = 1'b0;
        repeat (70) begin
            @(posedge clk);
            #1;
            if (out_valid) saw_valid = 1'b1;
        end
        checkOutput("abort.no_output", 64'(saw_valid), 64'd0);
        applyStimulus("post_abort_add", OP_ADD, 64'd1, 64'd1, 6'd0);
        checkAlu("post_abort_add", 64'd2, 1'b0, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
